// File: rtl/tt_um_franco_mezzarapa.sv
// ---------------------------------------------------------------------------
// tt_um_franco_mezzarapa
// Serial XOR cipher tile. A KEY_SIZE-bit key and a MSG_SIZE-bit message are
// shifted in MSB first. Every KEY_SIZE-bit chunk of the message is XORed with
// the key, and the ciphertext is streamed out MSB first with a valid flag.
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   ena      tile enable (ignored, block is always active)
//   ui_in    [0] serial data in, [1] key load enable, [2] message load enable
//   uo_out   [0] serial ciphertext, [1] output valid, [2] encrypt status
//   uio_in   unused
//   uio_out  tied to 0
//   uio_oe   tied to 0 (all bidirectional pins are inputs)
// ---------------------------------------------------------------------------
module tt_um_franco_mezzarapa #(
    parameter int MSG_SIZE = 128,
    parameter int KEY_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int CW = $clog2(MSG_SIZE) + 1;

    typedef enum logic [1:0] {IDLE, ENCRYPT, TX} state_t;

    state_t              state_q,   state_d;
    logic [KEY_SIZE-1:0] key_q,     key_d;
    logic [MSG_SIZE-1:0] msg_q,     msg_d;
    logic [MSG_SIZE-1:0] ct_q,      ct_d;
    logic [CW-1:0]       msg_cnt_q, msg_cnt_d;
    logic [CW-1:0]       tx_cnt_q,  tx_cnt_d;
    logic                valid_q,   valid_d;
    logic                enc_q,     enc_d;

    logic unused_ok;
    assign unused_ok = ^{ena, uio_in, ui_in[7:3]};

    always_comb begin
        state_d   = state_q;
        key_d     = key_q;
        msg_d     = msg_q;
        ct_d      = ct_q;
        msg_cnt_d = msg_cnt_q;
        tx_cnt_d  = tx_cnt_q;
        valid_d   = valid_q;
        enc_d     = enc_q;

        case (state_q)
            IDLE: begin
                if (ui_in[1]) begin
                    // Key load wins over message load; a longer burst keeps the last bits.
                    key_d = {key_q[KEY_SIZE-2:0], ui_in[0]};
                end else if (ui_in[2]) begin
                    msg_d = {msg_q[MSG_SIZE-2:0], ui_in[0]};
                    if (msg_cnt_q == CW'(MSG_SIZE - 1)) begin
                        msg_cnt_d = '0;
                        state_d   = ENCRYPT;
                        enc_d     = 1'b1;
                    end else begin
                        msg_cnt_d = msg_cnt_q + CW'(1);
                    end
                end else begin
                    // Message must arrive as one contiguous burst.
                    msg_cnt_d = '0;
                end
            end
            ENCRYPT: begin
                for (int i = 0; i < MSG_SIZE / KEY_SIZE; i++)
                    ct_d[i*KEY_SIZE +: KEY_SIZE] = msg_q[i*KEY_SIZE +: KEY_SIZE] ^ key_q;
                state_d  = TX;
                tx_cnt_d = '0;
                enc_d    = 1'b0;
                valid_d  = 1'b1;
            end
            TX: begin
                // Zero fill: once all bits are out the register is clear, so the
                // serial output reads 0 whenever no stream is active.
                ct_d = {ct_q[MSG_SIZE-2:0], 1'b0};
                if (tx_cnt_q == CW'(MSG_SIZE - 1)) begin
                    tx_cnt_d = '0;
                    state_d  = IDLE;
                    valid_d  = 1'b0;
                end else begin
                    tx_cnt_d = tx_cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                enc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            key_q     <= '0;
            msg_q     <= '0;
            ct_q      <= '0;
            msg_cnt_q <= '0;
            tx_cnt_q  <= '0;
            valid_q   <= 1'b0;
            enc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            key_q     <= key_d;
            msg_q     <= msg_d;
            ct_q      <= ct_d;
            msg_cnt_q <= msg_cnt_d;
            tx_cnt_q  <= tx_cnt_d;
            valid_q   <= valid_d;
            enc_q     <= enc_d;
        end
    end

    // Every output bit comes straight from a flop.
    assign uo_out  = {5'b0, enc_q, valid_q, ct_q[MSG_SIZE-1]};
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_franco_mezzarapa.sv
module tb_tt_um_franco_mezzarapa;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b0;
    logic [7:0] ui_in = 8'h00;
    logic [7:0] uo_out;
    logic [7:0] uio_in = 8'h00;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;
    int bits_seen = 0;
    int valid_rises = 0;
    logic prev_valid = 1'b0;
    logic prev_enc = 1'b0;
    logic exp_q[$];

    always #5 clk = ~clk;

    tt_um_franco_mezzarapa dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: expected ciphertext bits, MSB first.
    task automatic push_exp(input logic [127:0] e);
        for (int i = 127; i >= 0; i--) exp_q.push_back(e[i]);
    endtask

    task automatic send_key(input logic [15:0] k, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            @(negedge clk);
            ui_in = {5'b0, 1'b0, 1'b1, k[i]};
        end
        @(negedge clk);
        ui_in = 8'h00;
    endtask

    // Sends the top n bits of m, MSB first, as one burst.
    task automatic send_msg(input logic [127:0] m, input int n);
        for (int j = 0; j < n; j++) begin
            @(negedge clk);
            ui_in = {5'b0, 1'b1, 1'b0, m[127-j]};
        end
        @(negedge clk);
        ui_in = 8'h00;
    endtask

    task automatic wait_bits(input int target);
        int cyc = 0;
        while (bits_seen < target && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (bits_seen < target) chk("wait_bits_timeout", 128'(bits_seen), 128'(target));
    endtask

    task automatic wait_drain();
        int cyc = 0;
        while ((exp_q.size() != 0 || uo_out[1]) && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'd0);
    endtask

    // Monitor: compares every streamed bit against the scoreboard.
    always @(negedge clk) begin
        if (rst_n) begin
            if (uo_out[1]) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 128'd1, 128'd0);
                end else begin
                    chk("ct_bit", 128'(uo_out[0]), 128'(exp_q.pop_front()));
                    bits_seen++;
                end
            end else begin
                chk("idle_dout", 128'(uo_out[0]), 128'd0);
            end
            chk("upper_bits", 128'(uo_out[7:3]), 128'd0);
            // Encrypt status lasts one cycle and is followed directly by valid.
            if (prev_enc) chk("enc_to_valid", 128'({uo_out[2], uo_out[1]}), 128'b01);
            if (uo_out[1] && !prev_valid) valid_rises++;
            prev_valid = uo_out[1];
            prev_enc   = uo_out[2];
        end else begin
            prev_valid = 1'b0;
            prev_enc   = 1'b0;
        end
    end

    initial begin
        int base;
        int rises0;

        // 1: asynchronous reset with ena low
        #2 rst_n = 1'b0;
        #1;
        chk("reset_uo_out",  128'(uo_out),  128'h00);
        chk("reset_uio_out", 128'(uio_out), 128'h00);
        chk("reset_uio_oe",  128'(uio_oe),  128'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 2: key A5 with reference vector
        send_key(16'h00A5, 8);
        repeat (5) @(negedge clk);
        push_exp(128'h76EE2AB70460C89BEA048EC9D83B8A9F);
        send_msg(128'hD34B8F12A1C56D3E4FA12B6C7D9E2F3A, 128);
        wait_drain();

        // 3: key 00 echoes plaintext; key FF inverts zeros
        send_key(16'h0000, 8);
        push_exp(128'h0123456789ABCDEFFEDCBA9876543210);
        send_msg(128'h0123456789ABCDEFFEDCBA9876543210, 128);
        wait_drain();
        send_key(16'h00FF, 8);
        push_exp({128{1'b1}});
        send_msg(128'h0, 128);
        wait_drain();

        // 4: over-long key burst keeps the last 8 bits
        send_key(16'h0F3C, 12);
        push_exp({16{8'h3C}});
        send_msg(128'h0, 128);
        wait_drain();

        // 5: broken burst discarded; load pulse during TX has no effect
        send_key(16'h005A, 8);
        rises0 = valid_rises;
        send_msg({128{1'b1}}, 64);
        repeat (10) @(negedge clk);
        base = bits_seen;
        push_exp({16{8'h55}});
        send_msg({16{8'h0F}}, 128);
        wait_bits(base + 20);
        for (int i = 0; i < 10; i++) begin
            ui_in = {5'b0, 1'b1, 1'b0, i[0]};
            @(negedge clk);
        end
        ui_in = 8'h00;
        wait_drain();
        chk("single_valid_rise", 128'(valid_rises), 128'(rises0 + 1));

        // 6: reset mid-TX aborts; key returns to 0
        send_key(16'h00C3, 8);
        base = bits_seen;
        push_exp({16{8'hC3 ^ 8'h11}});
        send_msg({16{8'h11}}, 128);
        wait_bits(base + 40);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_uo_out", 128'(uo_out[1:0]), 128'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        push_exp(128'hCAFEBABE0000FFFF1234567887654321);
        send_msg(128'hCAFEBABE0000FFFF1234567887654321, 128);
        wait_drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
